grf_wb_arbiter: RTL and testbench

Shares the single GRF write port between the pipeline writeback stage and a multi-cycle side unit (mul/div or coprocessor result path). Pipeline writes pass straight through with priority; side results are queued in a small FIFO and drained into idle write-port cycles. An age counter prevents starvation. A hazard output tells the decode stage when a source register still has a queued write.

---
 rtl/grf_wb_arbiter_pkg.sv | 18 +
 rtl/grf_wb_arbiter_fifo.sv | 77 +++++++
 rtl/grf_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_grf_wb_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/grf_wb_arbiter_pkg.sv
// Shared GRF write-path definitions: register/data widths, the $0 register,
// and the side-result FIFO entry layout {live, a3, wd, pc}.
package grf_defs;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // One queued side result; live drops when a younger write to a3 supersedes it.
  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] a3;
    logic [DATA_W-1:0]     wd;
    logic [DATA_W-1:0]     pc;
  } wb_entry_t;

endpackage

// File: rtl/grf_wb_arbiter_fifo.sv
// wb_fifo: synchronous side-result FIFO with kill-by-address.
// Ports:
//   clk, reset        clock, synchronous active-high reset (discards all entries)
//   push, push_entry  enqueue one entry (caller guarantees not full)
//   pop               dequeue head (caller guarantees not empty)
//   kill_en, kill_a3  mark every stored entry, and the entry being pushed, with a3 == kill_a3 dead
//   head, count       current head entry and occupancy
//   live_mask, a3s    per-slot live flag and destination, for the hazard compare
module wb_fifo
  import grf_defs::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_a3,
  output wb_entry_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic [DEPTH-1:0]      live_mask,
  output logic [REG_ADDR_W-1:0] a3s [DEPTH]
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_live;

  // A concurrent pipeline write to the same register supersedes the incoming entry.
  always_comb begin
    push_live = push_entry.live && !(kill_en && (push_entry.a3 == kill_a3));
    head      = mem[rd_ptr];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      live_mask[i] = mem[PTR_W'(i)].live;
      a3s[i]       = mem[PTR_W'(i)].a3;
    end
  end

  // Storage and pointers; popped slots have live cleared so live implies occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill_en && (mem[PTR_W'(i)].a3 == kill_a3)) begin
          mem[PTR_W'(i)].live <= 1'b0;
        end
      end
      if (pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr           <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        mem[wr_ptr] <= '{live: push_live, a3: push_entry.a3,
                         wd: push_entry.wd, pc: push_entry.pc};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the single GRF write port between the pipeline
// writeback stage (priority, zero latency) and a queued multi-cycle side unit.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   wb_we/a3/wd/pc, wb_ready        pipeline write request and acceptance
//   md_valid/a3/wd/pc, md_ready     side result handshake
//   rs_a, rt_a, hazard              decode sources vs. live queued writes
//   grf_we/a3/wd/pc                 GRF write port (pc for the write log)
module grf_wb_arbiter
  import grf_defs::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_a3,
  input  logic [DATA_W-1:0]     wb_wd,
  input  logic [DATA_W-1:0]     wb_pc,
  output logic                  wb_ready,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] md_a3,
  input  logic [DATA_W-1:0]     md_wd,
  input  logic [DATA_W-1:0]     md_pc,
  input  logic [REG_ADDR_W-1:0] rs_a,
  input  logic [REG_ADDR_W-1:0] rt_a,
  output logic                  hazard,
  output logic                  grf_we,
  output logic [REG_ADDR_W-1:0] grf_a3,
  output logic [DATA_W-1:0]     grf_wd,
  output logic [DATA_W-1:0]     grf_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned AGE_W = $clog2(MAX_WAIT + 1);

  wb_entry_t             head;
  wb_entry_t             push_entry;
  logic [CNT_W-1:0]      count;
  logic [DEPTH-1:0]      live_mask;
  logic [REG_ADDR_W-1:0] a3s [DEPTH];
  logic [AGE_W-1:0]      age;

  logic head_live;
  logic head_dead;
  logic force_head;
  logic wb_use;
  logic wb_grant;
  logic head_grant;
  logic pop;
  logic push;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (wb_grant),
    .kill_a3    (wb_a3),
    .head       (head),
    .count      (count),
    .live_mask  (live_mask),
    .a3s        (a3s)
  );

  // Grant/force decisions; writes to $0 are accepted but never use the port.
  always_comb begin
    head_live  = (count != '0) && head.live;
    head_dead  = (count != '0) && !head.live;
    force_head = head_live && (age == AGE_W'(MAX_WAIT));
    wb_use     = wb_we && (wb_a3 != ZERO_REG);
    wb_grant   = !reset && wb_use && !force_head;
    head_grant = !reset && head_live && (!wb_use || force_head);
    // Dead heads drain one per cycle independent of port use.
    pop        = !reset && (head_grant || head_dead);
    wb_ready   = !reset && !force_head;
    md_ready   = !reset && (count < CNT_W'(DEPTH));
    push       = md_valid && md_ready;
    push_entry = '{live: (md_a3 != ZERO_REG), a3: md_a3, wd: md_wd, pc: md_pc};
  end

  // Write-port mux.
  always_comb begin
    grf_we = 1'b0;
    grf_a3 = ZERO_REG;
    grf_wd = '0;
    grf_pc = '0;
    if (wb_grant) begin
      grf_we = 1'b1;
      grf_a3 = wb_a3;
      grf_wd = wb_wd;
      grf_pc = wb_pc;
    end else if (head_grant) begin
      grf_we = 1'b1;
      grf_a3 = head.a3;
      grf_wd = head.wd;
      grf_pc = head.pc;
    end
  end

  // Decode hazard: live queued entries plus a side result entering this cycle.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_mask[i] && (((rs_a != ZERO_REG) && (a3s[i] == rs_a)) ||
                           ((rt_a != ZERO_REG) && (a3s[i] == rt_a)))) begin
        hazard = 1'b1;
      end
    end
    if (push && (md_a3 != ZERO_REG) &&
        (((rs_a != ZERO_REG) && (md_a3 == rs_a)) ||
         ((rt_a != ZERO_REG) && (md_a3 == rt_a)))) begin
      hazard = 1'b1;
    end
  end

  // Age of the live head: counts denied cycles, saturates, clears on pop.
  always_ff @(posedge clk) begin
    if (reset || pop) begin
      age <= '0;
    end else if (head_live && !head_grant && (age != AGE_W'(MAX_WAIT))) begin
      age <= age + AGE_W'(1);
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: each cycle's expected port outputs are
// queued when the stimulus is driven and compared at the following negedge.
module tb_grf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd;
  logic [31:0] wb_pc;
  logic        wb_ready;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_a3;
  logic [31:0] md_wd;
  logic [31:0] md_pc;
  logic [4:0]  rs_a;
  logic [4:0]  rt_a;
  logic        hazard;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;

  grf_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_we    (wb_we),
    .wb_a3    (wb_a3),
    .wb_wd    (wb_wd),
    .wb_pc    (wb_pc),
    .wb_ready (wb_ready),
    .md_valid (md_valid),
    .md_ready (md_ready),
    .md_a3    (md_a3),
    .md_wd    (md_wd),
    .md_pc    (md_pc),
    .rs_a     (rs_a),
    .rt_a     (rt_a),
    .hazard   (hazard),
    .grf_we   (grf_we),
    .grf_a3   (grf_a3),
    .grf_wd   (grf_wd),
    .grf_pc   (grf_pc)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        wbr;
    logic        mdr;
    logic        hz;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] grf_model [32];
  int          checks = 0;
  int          errors = 0;
  int          cycle_no = 0;
  logic        sb_on = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pc_of(input logic [31:0] wd);
    return wd + 32'h0040_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cycle_no, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what the ports must show in it.
  task automatic cyc(input logic rst,
                     input logic we, input logic [4:0] a3, input logic [31:0] wd,
                     input logic mv, input logic [4:0] ma3, input logic [31:0] mwd,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic e_we, input logic [4:0] e_a3, input logic [31:0] e_wd,
                     input logic e_wbr, input logic e_mdr, input logic e_hz);
    reset    = rst;
    wb_we    = we;
    wb_a3    = a3;
    wb_wd    = wd;
    wb_pc    = pc_of(wd);
    md_valid = mv;
    md_a3    = ma3;
    md_wd    = mwd;
    md_pc    = pc_of(mwd);
    rs_a     = rs;
    rt_a     = rt;
    exp_q.push_back('{we: e_we, a3: e_a3, wd: e_wd, wbr: e_wbr, mdr: e_mdr, hz: e_hz});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: one queued expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_on) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("grf_we", 32'(grf_we), 32'(e.we));
        if (e.we) begin
          chk("grf_a3", 32'(grf_a3), 32'(e.a3));
          chk("grf_wd", grf_wd, e.wd);
          chk("grf_pc", grf_pc, pc_of(e.wd));
        end
        chk("wb_ready", 32'(wb_ready), 32'(e.wbr));
        chk("md_ready", 32'(md_ready), 32'(e.mdr));
        chk("hazard", 32'(hazard), 32'(e.hz));
      end
      if (grf_we) grf_model[grf_a3] = grf_wd;
      cycle_no++;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) grf_model[i] = 32'h0;
    reset = 1'b1; wb_we = 1'b0; wb_a3 = '0; wb_wd = '0; wb_pc = '0;
    md_valid = 1'b0; md_a3 = '0; md_wd = '0; md_pc = '0; rs_a = '0; rt_a = '0;
    @(posedge clk);
    #1;
    sb_on = 1'b1;

    // Reset cycle, then idle reset state.
    cyc(1, 0,0,0,      0,0,0,      0,0,  0,0,0,        0,0,0);
    cyc(0, 0,0,0,      0,0,0,      0,0,  0,0,0,        1,1,0);

    // Pipeline only.
    repeat (3) cyc(0, 1,8,32'h1234, 0,0,0, 0,0, 1,8,32'h1234, 1,1,0);

    // Idle-slot drain.
    cyc(0, 0,0,0,      1,9,32'hAA, 9,0,  0,0,0,        1,1,1);
    cyc(0, 0,0,0,      0,0,0,      0,9,  1,9,32'hAA,   1,1,1);
    cyc(0, 0,0,0,      0,0,0,      9,0,  0,0,0,        1,1,0);

    // Starvation: head forced after 4 denied cycles, pipeline held meanwhile.
    cyc(0, 1,7,32'h77, 1,5,32'h55, 5,0,  1,7,32'h77,   1,1,1);
    repeat (4) cyc(0, 1,7,32'h77, 0,0,0, 5,0, 1,7,32'h77, 1,1,1);
    cyc(0, 1,7,32'h77, 0,0,0,      5,0,  1,5,32'h55,   0,1,1);
    cyc(0, 1,7,32'h77, 0,0,0,      5,0,  1,7,32'h77,   1,1,0);

    // Full: third push stalls until the forced pop frees a slot.
    cyc(0, 1,10,32'h100, 1,11,32'hB1, 0,0, 1,10,32'h100, 1,1,0);
    cyc(0, 1,10,32'h100, 1,12,32'hB2, 0,0, 1,10,32'h100, 1,1,0);
    repeat (3) cyc(0, 1,10,32'h100, 1,13,32'hB3, 0,0, 1,10,32'h100, 1,0,0);
    cyc(0, 1,10,32'h100, 1,13,32'hB3, 0,0, 1,11,32'hB1, 0,0,0);
    cyc(0, 1,10,32'h100, 1,13,32'hB3, 0,0, 1,10,32'h100, 1,1,0);
    cyc(0, 0,0,0,      0,0,0,      0,0,  1,12,32'hB2,  1,0,0);
    cyc(0, 0,0,0,      0,0,0,      0,0,  1,13,32'hB3,  1,1,0);
    cyc(0, 0,0,0,      0,0,0,      0,0,  0,0,0,        1,1,0);

    // Squash: queued $3 superseded by a pipeline write to $3.
    cyc(0, 1,4,32'h44, 1,3,32'h11, 3,0,  1,4,32'h44,   1,1,1);
    cyc(0, 1,3,32'h22, 0,0,0,      3,0,  1,3,32'h22,   1,1,1);
    cyc(0, 0,0,0,      0,0,0,      3,0,  0,0,0,        1,1,0);
    cyc(0, 0,0,0,      0,0,0,      3,0,  0,0,0,        1,1,0);

    // Side result killed by a pipeline write to the same register in the same cycle.
    cyc(0, 1,6,32'h66, 1,6,32'h60, 0,0,  1,6,32'h66,   1,1,0);
    cyc(0, 0,0,0,      0,0,0,      6,0,  0,0,0,        1,1,0);
    cyc(0, 0,0,0,      0,0,0,      0,6,  0,0,0,        1,1,0);

    // Reset with two live entries queued: nothing drains afterwards.
    cyc(0, 1,14,32'hE0, 1,15,32'hF1, 0,0, 1,14,32'hE0, 1,1,0);
    cyc(0, 1,14,32'hE0, 1,16,32'hF2, 15,0, 1,14,32'hE0, 1,1,1);
    cyc(1, 1,14,32'hE0, 0,0,0,      0,0,  0,0,0,        0,0,0);
    cyc(0, 0,0,0,      0,0,0,      15,16, 0,0,0,       1,1,0);
    cyc(0, 0,0,0,      0,0,0,      16,0,  0,0,0,       1,1,0);

    // Writes to $0 from either side are accepted and never reach the port.
    cyc(0, 0,0,0,      1,0,32'hDEAD, 0,0, 0,0,0,       1,1,0);
    cyc(0, 0,0,0,      0,0,0,      0,0,  0,0,0,        1,1,0);
    cyc(0, 1,0,32'hBAD, 0,0,0,     0,0,  0,0,0,        1,1,0);
    cyc(0, 0,0,0,      0,0,0,      0,0,  0,0,0,        1,1,0);

    sb_on = 1'b0;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("grf3_final", grf_model[3], 32'h22);
    chk("grf9_final", grf_model[9], 32'hAA);
    chk("grf5_final", grf_model[5], 32'h55);
    chk("grf13_final", grf_model[13], 32'hB3);
    chk("grf0_untouched", grf_model[0], 32'h0);
    chk("grf15_dropped", grf_model[15], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
